// File: rtl/br_flow_serializer.sv
// Ready/valid width-reducing serializer: splits each wide push flit into narrow pop flits,
// optionally truncating the final flit of a packet by a don't-care count.
module br_flow_serializer #(
    parameter int PushWidth                     = 2,
    parameter int PopWidth                      = 1,
    parameter int MetadataWidth                 = 1,
    parameter bit SerializeMostSignificantFirst = 1'b1,
    parameter bit EnableAssertFinalNotValid     = 1'b1,
    localparam int SerializationRatio           = PushWidth / PopWidth,
    localparam int SerFlitIdWidth               = SerializationRatio > 1 ? $clog2(SerializationRatio) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      push_ready,
    input  logic                      push_valid,
    input  logic [PushWidth-1:0]      push_data,
    input  logic                      push_last,
    input  logic [SerFlitIdWidth-1:0] push_last_dont_care_count,
    input  logic [MetadataWidth-1:0]  push_metadata,
    input  logic                      pop_ready,
    output logic                      pop_valid,
    output logic [PopWidth-1:0]       pop_data,
    output logic                      pop_last,
    output logic [MetadataWidth-1:0]  pop_metadata
);

    if (PopWidth < 1) begin : gen_bad_pop_width
        $error("PopWidth must be at least 1");
    end
    if (PushWidth % PopWidth != 0) begin : gen_bad_ratio
        $error("PushWidth must be an integer multiple of PopWidth");
    end
    if (MetadataWidth < 1) begin : gen_bad_metadata_width
        $error("MetadataWidth must be at least 1");
    end

    // Outputs are forced idle while in reset so downstream never sees a stale flit.
    assign pop_valid    = rst_n & push_valid;
    assign pop_metadata = push_metadata;

    if (SerializationRatio == 1) begin : gen_passthrough
        logic unused_inputs;

        assign push_ready    = rst_n & pop_ready;
        assign pop_last      = rst_n & push_last;
        assign pop_data      = push_data;
        assign unused_inputs = ^push_last_dont_care_count;
    end else begin : gen_ser
        logic [SerializationRatio-1:0][PopWidth-1:0] slices;
        logic [SerFlitIdWidth-1:0] flit_id;
        logic [SerFlitIdWidth-1:0] flit_id_next;
        logic [SerFlitIdWidth-1:0] last_id;
        logic [SerFlitIdWidth-1:0] slice_idx;
        logic                      at_last;

        assign slices  = push_data;
        assign at_last = (flit_id == last_id);

        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        always_comb begin
            last_id      = SerFlitIdWidth'(SerializationRatio - 1);
            flit_id_next = flit_id;
            if (push_last) begin
                last_id = last_id - push_last_dont_care_count;
            end
            if (pop_valid && pop_ready) begin
                flit_id_next = at_last ? '0 : flit_id + SerFlitIdWidth'(1);
            end
        end

        // NOTE: sequential state uses non-blocking assignments only, with the reset branch first.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                flit_id <= '0;
            end else begin
                flit_id <= flit_id_next;
            end
        end

        if (SerializeMostSignificantFirst) begin : gen_msb_first
            assign slice_idx = SerFlitIdWidth'(SerializationRatio - 1) - flit_id;
        end else begin : gen_lsb_first
            assign slice_idx = flit_id;
        end

        assign pop_data   = slices[slice_idx];
        assign pop_last   = rst_n & push_last & at_last;
        assign push_ready = rst_n & pop_ready & at_last;

`ifndef SYNTHESIS
        a_dont_care_in_range: assert property (@(posedge clk) disable iff (!rst_n)
            push_valid |-> (32'(push_last_dont_care_count) < SerializationRatio))
            else $error("push_last_dont_care_count out of range");
        a_dont_care_needs_last: assert property (@(posedge clk) disable iff (!rst_n)
            (push_valid && !push_last) |-> (push_last_dont_care_count == '0))
            else $error("push_last_dont_care_count nonzero without push_last");
`endif
    end

`ifndef SYNTHESIS
    a_push_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_data) && $stable(push_last)
            && $stable(push_last_dont_care_count) && $stable(push_metadata)))
        else $error("push signals changed while stalled");
    a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_data) && $stable(pop_last)
            && $stable(pop_metadata)))
        else $error("pop signals changed while stalled");

    final begin
        if (EnableAssertFinalNotValid) begin
            assert (!push_valid && !pop_valid)
                else $error("valid still asserted at end of simulation");
        end
    end
`endif

endmodule

// File: tb/tb_br_flow_serializer.sv
// Bench for br_flow_serializer: MSB-first and LSB-first 32->8 instances share stimulus and
// are checked against a queue-of-slices model; an 8->8 instance covers passthrough.
module tb_br_flow_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        push_valid = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_last = 1'b0;
    logic [1:0]  push_dcc = '0;
    logic [3:0]  push_meta = '0;
    logic        pop_ready = 1'b0;

    logic       msb_push_ready, msb_pop_valid, msb_pop_last;
    logic [7:0] msb_pop_data;
    logic [3:0] msb_pop_meta;
    logic       lsb_push_ready, lsb_pop_valid, lsb_pop_last;
    logic [7:0] lsb_pop_data;
    logic [3:0] lsb_pop_meta;

    logic       p_push_valid = 1'b0;
    logic [7:0] p_push_data = '0;
    logic       p_push_last = 1'b0;
    logic [0:0] p_dcc = '0;
    logic [0:0] p_meta = '0;
    logic       p_pop_ready = 1'b0;
    logic       p_push_ready, p_pop_valid, p_pop_last;
    logic [7:0] p_pop_data;
    logic [0:0] p_pop_meta;

    br_flow_serializer #(
        .PushWidth(32), .PopWidth(8), .MetadataWidth(4), .SerializeMostSignificantFirst(1'b1)
    ) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .push_ready(msb_push_ready), .push_valid(push_valid), .push_data(push_data),
        .push_last(push_last), .push_last_dont_care_count(push_dcc), .push_metadata(push_meta),
        .pop_ready(pop_ready), .pop_valid(msb_pop_valid), .pop_data(msb_pop_data),
        .pop_last(msb_pop_last), .pop_metadata(msb_pop_meta)
    );

    br_flow_serializer #(
        .PushWidth(32), .PopWidth(8), .MetadataWidth(4), .SerializeMostSignificantFirst(1'b0)
    ) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .push_ready(lsb_push_ready), .push_valid(push_valid), .push_data(push_data),
        .push_last(push_last), .push_last_dont_care_count(push_dcc), .push_metadata(push_meta),
        .pop_ready(pop_ready), .pop_valid(lsb_pop_valid), .pop_data(lsb_pop_data),
        .pop_last(lsb_pop_last), .pop_metadata(lsb_pop_meta)
    );

    br_flow_serializer #(
        .PushWidth(8), .PopWidth(8), .MetadataWidth(1)
    ) dut_pass (
        .clk(clk), .rst_n(rst_n),
        .push_ready(p_push_ready), .push_valid(p_push_valid), .push_data(p_push_data),
        .push_last(p_push_last), .push_last_dont_care_count(p_dcc), .push_metadata(p_meta),
        .pop_ready(p_pop_ready), .pop_valid(p_pop_valid), .pop_data(p_pop_data),
        .pop_last(p_pop_last), .pop_metadata(p_pop_meta)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the presented wide flit becomes a queue of expected narrow flits.
    typedef struct {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       last;
    } slice_t;

    slice_t exp_q[$];
    bit     flit_done;
    int     handshakes = 0;

    task automatic fill_model();
        int n;
        slice_t s;
        n = push_last ? 4 - int'(push_dcc) : 4;
        for (int i = 0; i < n; i++) begin
            s.msb  = 8'(push_data >> (8 * (3 - i)));
            s.lsb  = 8'(push_data >> (8 * i));
            s.last = push_last && (i == n - 1);
            exp_q.push_back(s);
        end
    endtask

    task automatic compare_and_model();
        if (!rst_n) begin
            check("rst_msb_pop_valid", msb_pop_valid, 0);
            check("rst_msb_push_ready", msb_push_ready, 0);
            check("rst_msb_pop_last", msb_pop_last, 0);
            check("rst_lsb_pop_valid", lsb_pop_valid, 0);
            check("rst_lsb_push_ready", lsb_push_ready, 0);
            check("rst_pass_pop_valid", p_pop_valid, 0);
            check("rst_pass_push_ready", p_push_ready, 0);
            exp_q.delete();
            return;
        end
        check("msb_pop_valid", msb_pop_valid, push_valid);
        check("lsb_pop_valid", lsb_pop_valid, push_valid);
        if (!push_valid) return;
        if (exp_q.size() == 0) fill_model();
        check("msb_pop_data", msb_pop_data, exp_q[0].msb);
        check("lsb_pop_data", lsb_pop_data, exp_q[0].lsb);
        check("msb_pop_last", msb_pop_last, exp_q[0].last);
        check("lsb_pop_last", lsb_pop_last, exp_q[0].last);
        check("msb_pop_meta", msb_pop_meta, push_meta);
        check("lsb_pop_meta", lsb_pop_meta, push_meta);
        check("msb_push_ready", msb_push_ready, pop_ready && exp_q.size() == 1);
        check("lsb_push_ready", lsb_push_ready, pop_ready && exp_q.size() == 1);
        if (pop_ready) begin
            void'(exp_q.pop_front());
            handshakes++;
            if (exp_q.size() == 0) flit_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_and_model();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [31:0] data, input logic last, input logic [1:0] dcc,
                             input logic [3:0] meta, input int stall_at, input int stall_len);
        push_valid = 1'b1;
        push_data  = data;
        push_last  = last;
        push_dcc   = dcc;
        push_meta  = meta;
        flit_done  = 1'b0;
        for (int c = 0; c < 64 && !flit_done; c++) begin
            pop_ready = !(c >= stall_at && c < stall_at + stall_len);
            tick();
        end
        check("flit_timeout", flit_done, 1);
    endtask

    int hs_start;

    initial begin
        // Reset with a flit presented: everything must stay idle.
        push_valid = 1'b1;
        push_data  = 32'hDEADBEEF;
        pop_ready  = 1'b1;
        p_push_valid = 1'b1;
        p_pop_ready  = 1'b1;
        tick();
        tick();
        push_valid   = 1'b0;
        p_push_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // MSB-first full flit.
        hs_start = handshakes;
        send_flit(32'hBAADF00D, 1'b1, 2'd0, 4'd3, 0, 0);
        check("full_flit_handshakes", handshakes - hs_start, 4);

        // Back-to-back packet with truncated final flit.
        hs_start = handshakes;
        send_flit(32'h01234567, 1'b0, 2'd0, 4'd2, 0, 0);
        send_flit(32'h77ADF00D, 1'b1, 2'd1, 4'd5, 0, 0);
        check("trunc_packet_handshakes", handshakes - hs_start, 7);

        // Backpressure while the second slice is presented.
        send_flit(32'hBAADF00D, 1'b1, 2'd0, 4'd1, 1, 3);

        // Maximum truncation: one narrow flit.
        hs_start = handshakes;
        send_flit(32'hBAADF00D, 1'b1, 2'd3, 4'd0, 0, 0);
        check("max_trunc_handshakes", handshakes - hs_start, 1);

        // Reset after two pops abandons the partial flit.
        push_valid = 1'b1;
        push_data  = 32'hBAADF00D;
        push_last  = 1'b1;
        push_dcc   = 2'd0;
        push_meta  = 4'd9;
        pop_ready  = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        push_data = 32'h11223344;
        tick();
        rst_n     = 1'b1;
        pop_ready = 1'b0;
        @(negedge clk);
        check("rst_first_pop", msb_pop_data, 32'h11);
        check("rst_first_valid", msb_pop_valid, 1);
        @(posedge clk);
        #1;
        send_flit(32'h11223344, 1'b1, 2'd0, 4'd9, 0, 0);
        push_valid = 1'b0;
        tick();

        // Passthrough instance.
        p_push_valid = 1'b1;
        p_push_data  = 8'h5A;
        p_push_last  = 1'b1;
        p_pop_ready  = 1'b1;
        @(negedge clk);
        check("pass_data", p_pop_data, 32'h5A);
        check("pass_last", p_pop_last, 1);
        check("pass_push_ready", p_push_ready, 1);
        check("pass_valid", p_pop_valid, 1);
        @(posedge clk);
        #1;
        p_push_data = 8'hC3;
        p_push_last = 1'b0;
        p_pop_ready = 1'b0;
        @(negedge clk);
        check("pass_stall_ready", p_push_ready, 0);
        check("pass_stall_last", p_pop_last, 0);
        check("pass_stall_data", p_pop_data, 32'hC3);
        @(posedge clk);
        #1;
        p_pop_ready = 1'b1;
        @(negedge clk);
        check("pass_resume_ready", p_push_ready, 1);
        @(posedge clk);
        #1;
        p_push_valid = 1'b0;

        // Randomized traffic; push signals only change once the model says the flit is consumed.
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (exp_q.size() == 0) begin
                push_valid = ($urandom_range(3) != 0);
                push_data  = $urandom;
                push_last  = $urandom_range(1);
                push_dcc   = push_last ? 2'($urandom_range(3)) : 2'd0;
                push_meta  = 4'($urandom);
            end
            pop_ready = ($urandom_range(3) != 0);
            tick();
        end
        // Drain any flit in progress, then go idle.
        pop_ready = 1'b1;
        for (int c = 0; c < 8 && exp_q.size() != 0; c++) tick();
        check("drain_empty", exp_q.size(), 0);
        push_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/br_flow_serializer.md
# br_flow_serializer

Ready/valid width-reducing serializer. Each wide push flit is split into `SerializationRatio` narrow pop flits. An optional `push_last` plus don't-care count truncates the final flit of a packet. It is the transmit-side counterpart of `br_flow_deserializer`, placed before narrow links so the far end can rebuild the original wide flits, packet boundaries and metadata.

## Interface
Parameters:
- `PushWidth`, 2: wide input flit width; must be a positive integer multiple of `PopWidth`.
- `PopWidth`, 1: narrow output flit width.
- `MetadataWidth`, 1: per-packet sideband width; passed through unchanged.
- `SerializeMostSignificantFirst`, 1: 1 means the first pop flit is `push_data[PushWidth-1 -: PopWidth]`; 0 means it is `push_data[PopWidth-1:0]`.
- `EnableAssertFinalNotValid`, 1: end-of-sim check that `push_valid` and `pop_valid` are 0.
- `SerializationRatio` (localparam) = `PushWidth/PopWidth`.
- `SerFlitIdWidth` (localparam) = `SerializationRatio>1 ? $clog2(SerializationRatio) : 1`.

Ports:
- `clk`  in  1: clock; all state on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `push_ready`  out  1: wide flit consumed this cycle.
- `push_valid`  in  1: wide flit valid.
- `push_data`  in  `PushWidth`: wide payload.
- `push_last`  in  1: wide flit ends its packet.
- `push_last_dont_care_count`  in  `SerFlitIdWidth`: number of trailing narrow flits to drop; only meaningful with `push_last`.
- `push_metadata`  in  `MetadataWidth`: packet sideband.
- `pop_ready`  in  1: downstream accepts narrow flit.
- `pop_valid`  out  1: narrow flit valid.
- `pop_data`  out  `PopWidth`: narrow payload slice.
- `pop_last`  out  1: last narrow flit of packet.
- `pop_metadata`  out  `MetadataWidth`: equals `push_metadata`.

## Operation
- State is a single flit counter `flit_id` (`SerFlitIdWidth` bits). Reset value is 0.
- `last_id` = `push_last ? SerializationRatio-1-push_last_dont_care_count : SerializationRatio-1`.
- Gating while `rst_n`=1:
  - `pop_valid` = `push_valid`.
  - `pop_metadata` = `push_metadata`.
  - `pop_last` = `push_last && flit_id==last_id`.
  - `push_ready` = `pop_ready && flit_id==last_id`.
- Slice selection:
  - MSB-first: `pop_data` = `push_data[(SerializationRatio-flit_id)*PopWidth-1 -: PopWidth]`.
  - LSB-first: `pop_data` = `push_data[flit_id*PopWidth +: PopWidth]`.
- Counter update on a pop handshake (`pop_valid && pop_ready`):
  - If `flit_id==last_id`, `flit_id` becomes 0.
  - Otherwise `flit_id` increments by 1.
  - Without a handshake, `flit_id` holds. It never exceeds `last_id`.
- `SerializationRatio==1` is a pure passthrough:
  - No counter is instantiated.
  - `push_ready` = `pop_ready`.
  - `pop_last` = `push_last`.
  - `push_last_dont_care_count` is ignored.
- Upstream obligations (the block asserts each one):
  - `push_valid && !push_ready` implies all push signals are stable next cycle.
  - `push_last_dont_care_count` < `SerializationRatio`.
  - `push_last_dont_care_count` is 0 when `!push_last`.
- Output guarantee (asserted): `pop_valid && !pop_ready` implies all pop signals are stable next cycle.
- Integer checks at elaboration: `PushWidth%PopWidth==0`, `PopWidth>=1`, `MetadataWidth>=1`.

## Timing
- Push to pop latency is zero cycles. `pop_*` is combinational from `push_*` and `flit_id`.
- Combinational paths:
  - `pop_ready` to `push_ready` exists.
  - `pop_ready` to `pop_valid` must not exist.
- A packet of N wide flits with final don't-care count D takes N*`SerializationRatio`-D pop handshakes.
- With `pop_ready`=1 throughout, throughput is 1 narrow flit per cycle with no bubbles between wide flits.
- Reset values (while `rst_n`=0):
  - Outputs: `pop_valid`=0, `push_ready`=0, `pop_last`=0. `pop_data` and `pop_metadata` are don't-care.
  - `flit_id` goes to 0 at the first clock edge with `rst_n`=0.
- Reset mid-packet: the partial wide flit is abandoned. The first pop after `rst_n` returns to 1 is slice 0 of whatever is presented. Upstream must also be reset.
- Simultaneous final pop handshake and new `push_valid`: the new flit's slice 0 appears the next cycle, with no idle cycle.

## Test plan
- MSB-first, 32→8, push `0xBAADF00D`, `push_last`=1, D=0, `pop_ready`=1.
  - Required: `pop_data` BA, AD, F0, 0D on 4 consecutive cycles.
  - `pop_last`=1 and `push_ready`=1 only on the 4th cycle.
- LSB-first, 32→8, back-to-back pushes `0x01234567` (`push_last`=0, metadata 2) then `0x??ADF00D` (`push_last`=1, D=1, metadata 5).
  - Required: 67, 45, 23, 01 with metadata 2, then 0D, F0, AD with metadata 5.
  - `pop_last`=1 on AD; 7 handshakes total.
- Backpressure, MSB-first `0xBAADF00D`: drop `pop_ready` for 3 cycles while AD is presented.
  - Required: `pop_data` holds AD, `flit_id` holds 1, `push_ready`=0.
  - Order resumes F0, 0D.
- Maximum truncation, MSB-first, D=3, `push_last`=1, `0xBAADF00D`.
  - Required: single pop flit BA with `pop_last`=1; `push_ready`=1 in the same cycle.
- Reset mid-packet: deassert `rst_n` after 2 pops.
  - Required: `pop_valid`=0 and `push_ready`=0 during reset.
  - After release, a new `0x11223344` (MSB-first) pops 11 first.
- Passthrough, `PushWidth`=`PopWidth`=8: push `0x5A` with `push_last`=1, D=0, `pop_ready`=1.
  - Required: `pop_data`=`0x5A`, `pop_last`=1, `push_ready`=1 in the same cycle.
